// File: rtl/icache_refill_if.sv
// Instruction-cache refill bus bundle.
// Groups the fetch-miss handshake, memory request/response, storage write
// port, lookup, flush and status signals of the refill engine.
//   master : fetch stage / memory side (drives requests, sees results)
//   slave  : the refill engine itself
interface icache_refill_if #(
  parameter int INDEX_BITS = 8
);
  logic                  miss_valid;
  logic                  miss_ready;
  logic [31:0]           miss_addr;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [31:0]           mem_req_addr;
  logic                  mem_rsp_valid;
  logic [31:0]           mem_rsp_data;
  logic                  wr_en;
  logic [INDEX_BITS+1:0] wr_addr;
  logic [31:0]           wr_data;
  logic                  lu_en;
  logic [31:0]           lu_addr;
  logic                  lu_hit;
  logic                  flush;
  logic                  busy;
  logic                  fill_done;

  modport master (
    output miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
           lu_en, lu_addr, flush,
    input  miss_ready, mem_req_valid, mem_req_addr, wr_en, wr_addr, wr_data,
           lu_hit, busy, fill_done
  );

  modport slave (
    input  miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
           lu_en, lu_addr, flush,
    output miss_ready, mem_req_valid, mem_req_addr, wr_en, wr_addr, wr_data,
           lu_hit, busy, fill_done
  );
endinterface

// File: rtl/icache_refill.sv
// Instruction-cache refill engine and tag store.
// On a fetch miss, requests the enclosing line from memory, streams the four
// returned words into the instruction storage write port, then commits the
// tag/valid entry. Also answers registered hit lookups.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : icache_refill_if.slave (miss handshake, memory request/response,
//            storage write port, lookup, flush, busy, fill_done)
//
// state  | meaning
// IDLE   | waiting for a miss; flush clears all valid bits
// REQ    | line request presented on the memory bus
// FILL   | writing returned words into storage, one per mem_rsp_valid
// COMMIT | write tag/valid (unless flushed meanwhile), pulse fill_done
module icache_refill #(
  parameter int LINE_WORDS = 4,
  parameter int INDEX_BITS = 8
) (
  input logic         clk,
  input logic         rst_n,
  icache_refill_if.slave bus
);
  localparam int WORD_BITS = $clog2(LINE_WORDS);
  localparam int OFF_BITS  = WORD_BITS + 2;
  localparam int TAG_LSB   = OFF_BITS + INDEX_BITS;
  localparam int TAG_BITS  = 32 - TAG_LSB;
  localparam int LINES     = 1 << INDEX_BITS;
  localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, FILL, COMMIT} state_t;

  state_t                 state_q;
  logic [LINES-1:0]       valid_q;
  logic [TAG_BITS-1:0]    tag_mem [LINES];
  logic [31-OFF_BITS:0]   line_q;        // captured {tag, index} of the miss
  logic [WORD_BITS-1:0]   cnt_q;
  logic                   flush_pend_q;
  logic                   lu_hit_q;

  logic [INDEX_BITS-1:0]  miss_idx, lu_idx, line_idx;
  logic [TAG_BITS-1:0]    lu_tag, line_tag;
  logic                   accept, beat;
  logic                   unused_addr_bits;

  assign miss_idx = bus.miss_addr[TAG_LSB-1:OFF_BITS];
  assign lu_idx   = bus.lu_addr[TAG_LSB-1:OFF_BITS];
  assign lu_tag   = bus.lu_addr[31:TAG_LSB];
  assign line_idx = line_q[INDEX_BITS-1:0];
  assign line_tag = line_q[31-OFF_BITS:INDEX_BITS];
  assign unused_addr_bits = ^{bus.miss_addr[OFF_BITS-1:0], bus.lu_addr[OFF_BITS-1:0]};

  assign bus.miss_ready = (state_q == IDLE) && !bus.flush;
  assign accept         = bus.miss_valid && bus.miss_ready;
  // Write path is combinational from the response so storage sees each beat
  // in the cycle it arrives.
  assign beat           = (state_q == FILL) && bus.mem_rsp_valid;

  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_req_addr  = (state_q == REQ) ? {line_q, {OFF_BITS{1'b0}}} : '0;
  assign bus.wr_en         = beat;
  assign bus.wr_addr       = beat ? {line_idx, cnt_q} : '0;
  assign bus.wr_data       = beat ? bus.mem_rsp_data : '0;
  assign bus.lu_hit        = lu_hit_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.fill_done     = (state_q == COMMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      line_q       <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      lu_hit_q     <= 1'b0;
    end else begin
      // Reads the tag store before any update made in this same cycle.
      lu_hit_q <= bus.lu_en && valid_q[lu_idx] && (tag_mem[lu_idx] == lu_tag);

      case (state_q)
        IDLE: begin
          if (bus.flush) begin
            valid_q <= '0;
          end else if (accept) begin
            line_q            <= bus.miss_addr[31:OFF_BITS];
            valid_q[miss_idx] <= 1'b0;
            state_q           <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            cnt_q   <= '0;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (bus.mem_rsp_valid) begin
            cnt_q <= cnt_q + WORD_BITS'(1);
            if (cnt_q == LAST_BEAT) state_q <= COMMIT;
          end
        end
        COMMIT: begin
          if (!flush_pend_q) valid_q[line_idx] <= 1'b1;
          flush_pend_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // A flush while busy overrides any valid update above, and poisons the
      // line in flight so its commit leaves it invalid.
      if (bus.flush && state_q != IDLE) begin
        valid_q <= '0;
        if (state_q != COMMIT) flush_pend_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == COMMIT && !flush_pend_q) tag_mem[line_idx] <= line_tag;
  end
endmodule

// File: tb/tb_icache_refill.sv
module tb_icache_refill;
  logic clk;
  logic rst_n;

  icache_refill_if #(.INDEX_BITS(8)) bus ();

  icache_refill #(.LINE_WORDS(4), .INDEX_BITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference tag store: what the cache should hold, by the address rules.
  bit [255:0] valid_m;
  bit [19:0]  tag_m [256];
  bit         pend_clr, pend_commit, pend_flush;
  bit [7:0]   pend_clr_idx, pc_idx;
  bit [19:0]  pc_tag;
  bit         lu_pend, lu_exp;
  bit         noise_ok;
  int         n_cmp, n_fail;
  logic [31:0] filled_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    return valid_m[a[11:4]] && (tag_m[a[11:4]] == a[31:12]);
  endfunction

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    if (filled_q.size() > 0 && $urandom_range(0, 2) != 0) begin
      a = filled_q[$urandom_range(0, filled_q.size() - 1)];
      a[3:0] = 4'($urandom);
    end else begin
      a = $urandom;
    end
    return a;
  endfunction

  task automatic set_lookup(input logic [31:0] a);
    bus.lu_en   = 1'b1;
    bus.lu_addr = a;
    lu_exp      = model_hit(a);
    lu_pend     = 1'b1;
  endtask

  // Advance one cycle: apply the updates the cache makes at this edge to the
  // model, check last cycle's lookup, then drive default inputs.
  task automatic tick();
    @(posedge clk);
    if (pend_clr) valid_m[pend_clr_idx] = 1'b0;
    if (pend_commit) begin
      valid_m[pc_idx] = 1'b1;
      tag_m[pc_idx]   = pc_tag;
    end
    if (pend_flush) valid_m = '0;
    pend_clr = 0; pend_commit = 0; pend_flush = 0;
    @(negedge clk);
    check("lu_hit", bus.lu_hit, lu_pend ? lu_exp : 1'b0);
    lu_pend           = 1'b0;
    bus.miss_valid    = 1'b0;
    bus.miss_addr     = $urandom;
    bus.flush         = 1'b0;
    bus.mem_rsp_valid = noise_ok ? 1'($urandom) : 1'b0;
    bus.mem_rsp_data  = $urandom;
    bus.mem_req_ready = noise_ok ? 1'($urandom) : 1'b0;
    if ($urandom_range(0, 1) == 1) set_lookup(pick_addr());
    else begin
      bus.lu_en   = 1'b0;
      bus.lu_addr = $urandom;
    end
  endtask

  task automatic fill(input logic [31:0] addr, input int req_stall, input int gap_beat,
                      input int gap_len, input int flush_beat, input int rst_beat,
                      input logic [31:0] probe, input bit fixed);
    logic [31:0] d [4];
    int cyc, exp_cyc;
    bit flushed;
    for (int b = 0; b < 4; b++) d[b] = fixed ? 32'hA0 + 32'(b) : $urandom;
    filled_q.push_back(addr);
    flushed = 0;
    cyc = 0;
    exp_cyc = 6 + req_stall + ((gap_beat < 4) ? gap_len : 0);

    tick();
    bus.miss_valid = 1'b1;
    bus.miss_addr  = addr;
    #1;
    check("accept_ready", bus.miss_ready, 1'b1);
    check("accept_busy", bus.busy, 1'b0);
    check("idle_wr_en", bus.wr_en, 1'b0);
    pend_clr = 1; pend_clr_idx = addr[11:4];
    noise_ok = 0;

    for (int s = 0; s <= req_stall; s++) begin
      tick(); cyc++;
      if (s == 0) set_lookup(probe);
      bus.mem_rsp_valid = 1'($urandom);
      bus.mem_req_ready = (s == req_stall);
      #1;
      check("req_valid", bus.mem_req_valid, 1'b1);
      check("req_addr", bus.mem_req_addr, {addr[31:4], 4'h0});
      check("req_busy", bus.busy, 1'b1);
      check("req_miss_ready", bus.miss_ready, 1'b0);
      check("req_wr_en", bus.wr_en, 1'b0);
    end

    for (int b = 0; b < 4; b++) begin
      if (b == gap_beat) begin
        for (int g = 0; g < gap_len; g++) begin
          tick(); cyc++;
          bus.mem_req_ready = 1'($urandom);
          #1;
          check("gap_wr_en", bus.wr_en, 1'b0);
          check("gap_req_valid", bus.mem_req_valid, 1'b0);
        end
      end
      tick(); cyc++;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = d[b];
      bus.mem_req_ready = 1'($urandom);
      if (b == flush_beat) begin
        bus.flush = 1'b1; flushed = 1; pend_flush = 1;
      end
      #1;
      check("beat_wr_en", bus.wr_en, 1'b1);
      check("beat_wr_addr", bus.wr_addr, {addr[11:4], 2'(b)});
      check("beat_wr_data", bus.wr_data, d[b]);
      check("beat_fill_done", bus.fill_done, 1'b0);
      if (b == rst_beat) begin
        rst_n = 1'b0;
        #1;
        check("rst_wr_en", bus.wr_en, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_req_valid", bus.mem_req_valid, 1'b0);
        check("rst_fill_done", bus.fill_done, 1'b0);
        valid_m = '0;
        pend_clr = 0; pend_commit = 0; pend_flush = 0;
        lu_pend = 0;
        tick();
        rst_n = 1'b1;
        noise_ok = 1;
        return;
      end
    end

    tick(); cyc++;
    bus.mem_rsp_valid = 1'($urandom);
    set_lookup(addr);
    #1;
    check("commit_fill_done", bus.fill_done, 1'b1);
    check("commit_busy", bus.busy, 1'b1);
    check("commit_wr_en", bus.wr_en, 1'b0);
    check("fill_done_cycle", 64'(cyc), 64'(exp_cyc));
    if (!flushed) begin
      pend_commit = 1; pc_idx = addr[11:4]; pc_tag = addr[31:12];
    end

    tick();
    #1;
    check("post_fill_done", bus.fill_done, 1'b0);
    check("post_busy", bus.busy, 1'b0);
    check("post_miss_ready", bus.miss_ready, 1'b1);
    check("post_req_valid", bus.mem_req_valid, 1'b0);
    noise_ok = 1;
  endtask

  task automatic idle_cycles(input int n, input bit rnd_flush);
    for (int i = 0; i < n; i++) begin
      tick();
      if (rnd_flush && $urandom_range(0, 5) == 0) begin
        bus.flush = 1'b1; pend_flush = 1;
      end
      #1;
      check("idle_busy", bus.busy, 1'b0);
      check("idle_wr_en", bus.wr_en, 1'b0);
      check("idle_miss_ready", bus.miss_ready, !bus.flush);
      check("idle_fill_done", bus.fill_done, 1'b0);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    valid_m = '0;
    pend_clr = 0; pend_commit = 0; pend_flush = 0; lu_pend = 0;
    noise_ok = 1;
    rst_n = 1'b1;
    bus.miss_valid = 1'b0; bus.miss_addr = '0; bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hDEAD_BEEF;
    bus.lu_en = 1'b1; bus.lu_addr = '0; bus.flush = 1'b0;
    #2 rst_n = 1'b0;

    @(negedge clk);
    #1;
    check("rst_miss_ready", bus.miss_ready, 1'b1);
    check("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_lu_hit", bus.lu_hit, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_fill_done", bus.fill_done, 1'b0);
    check("rst_mem_req_addr", bus.mem_req_addr, 32'h0);
    check("rst_wr_addr", bus.wr_addr, 10'h0);
    check("rst_wr_data", bus.wr_data, 32'h0);
    tick();
    rst_n = 1'b1;
    idle_cycles(2, 0);

    // Cold miss with minimum latency, then hit on the following cycle.
    fill(32'h0000_1234, 0, 4, 0, -1, -1, 32'h0000_1234, 1);
    set_lookup(32'h0000_123C);
    idle_cycles(1, 0);

    // Conflict in the same index: old line invalid from acceptance onward.
    fill(32'h0000_2230, 0, 4, 0, -1, -1, 32'h0000_1230, 0);
    set_lookup(32'h0000_2230);
    idle_cycles(1, 0);
    set_lookup(32'h0000_1230);
    idle_cycles(1, 0);

    // Stalled request and a two-cycle gap between beats 1 and 2.
    fill(32'h0000_5678, 3, 2, 2, -1, -1, 32'h0000_5678, 0);
    idle_cycles(1, 0);

    // Flush during FILL: the whole cache, including the line in flight, misses.
    fill(32'h0000_9A40, 1, 4, 0, -1, -1, 32'h0000_9A40, 0);
    fill(32'h0000_BC80, 0, 4, 0, 2, -1, 32'h0000_9A40, 0);
    set_lookup(32'h0000_9A40);
    idle_cycles(1, 0);
    set_lookup(32'h0000_BC80);
    idle_cycles(1, 0);

    // Flush and miss together in IDLE: miss refused, then taken next cycle.
    fill(32'h0000_1234, 0, 4, 0, -1, -1, 32'h0000_1234, 0);
    tick();
    bus.flush = 1'b1; bus.miss_valid = 1'b1; bus.miss_addr = 32'h0000_3300;
    pend_flush = 1;
    #1;
    check("flush_miss_ready", bus.miss_ready, 1'b0);
    fill(32'h0000_3300, 0, 4, 0, -1, -1, 32'h0000_1234, 0);

    // Reset mid-fill after beat 2.
    fill(32'h0000_4440, 0, 4, 0, -1, 2, 32'h0000_3300, 0);
    set_lookup(32'h0000_3300);
    idle_cycles(1, 0);
    set_lookup(32'h0000_4440);
    idle_cycles(1, 0);

    // Randomized fills over a small address pool to force conflicts.
    for (int it = 0; it < 40; it++) begin
      logic [31:0] a;
      logic [19:0] tg;
      logic [7:0]  ix;
      int          fb;
      tg = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'($urandom_range(1, 3));
      ix = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(8'h23, 8'h25));
      a  = {tg, ix, 4'($urandom)};
      fb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1;
      idle_cycles($urandom_range(0, 3), 1);
      fill(a, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2), fb, -1,
           pick_addr(), 0);
    end
    idle_cycles(2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
